// File: rtl/pattern_event_mon_if.sv
// Bundle of the pattern monitor's functional signals.
//   pattern   : detection flag from the upstream sequence detector
//   clr       : synchronous clear of statistics and burst FSM
//   clr_alarm : acknowledge of the sticky alarm
//   det_cnt   : saturating detection count
//   last_gap  : cycles between the two most recent detections
//   gap_valid : last_gap holds a real measurement
//   burst     : one-cycle pulse when a burst is found
//   alarm     : sticky burst flag
// master = stimulus/consumer side, slave = monitor side.
interface pattern_event_mon_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned GAP_W = 8
);
  logic             pattern;
  logic             clr;
  logic             clr_alarm;
  logic [CNT_W-1:0] det_cnt;
  logic [GAP_W-1:0] last_gap;
  logic             gap_valid;
  logic             burst;
  logic             alarm;

  modport master (
    output pattern, clr, clr_alarm,
    input  det_cnt, last_gap, gap_valid, burst, alarm
  );

  modport slave (
    input  pattern, clr, clr_alarm,
    output det_cnt, last_gap, gap_valid, burst, alarm
  );
endinterface

// File: rtl/pattern_event_mon.sv
// Detection statistics and burst alarm for an upstream pattern detector.
// Counts detections, measures the gap between the two most recent ones and
// raises a sticky alarm when BURST_N detections fall within WINDOW cycles.
// Ports:
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : pattern_event_mon_if.slave (pattern/clr/clr_alarm in,
//         det_cnt/last_gap/gap_valid/burst/alarm out, all registered)
module pattern_event_mon #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned GAP_W   = 8,
  parameter int unsigned BURST_N = 3,
  parameter int unsigned WINDOW  = 16
) (
  input  logic                clk,
  input  logic                rst,
  pattern_event_mon_if.slave  bus
);

  localparam int unsigned     GAP_XW     = GAP_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [GAP_W-1:0] GAP_MAX   = '1;
  localparam logic [3:0]       BURST_HITS = 4'(BURST_N);
  localparam logic [7:0]       WIN_LAST   = 8'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       hits_q, hits_d;
  logic [7:0]       win_q, win_d;
  logic [CNT_W-1:0] det_cnt_q, det_cnt_d;
  logic [GAP_W-1:0] since_q, since_d;
  logic [GAP_W-1:0] last_gap_q, last_gap_d;
  logic             gap_valid_q, gap_valid_d;
  logic             seen_q, seen_d;
  logic             burst_q, burst_d;
  logic             alarm_q, alarm_d;

  logic             det;
  logic [GAP_XW-1:0] gap_ext;
  logic [GAP_W-1:0] gap_meas;
  logic [7:0]       win_nxt;

  // A detection coinciding with clr is dropped.
  assign det      = bus.pattern & ~bus.clr;
  assign gap_ext  = {1'b0, since_q} + GAP_XW'(1);
  assign gap_meas = gap_ext[GAP_W] ? GAP_MAX : gap_ext[GAP_W-1:0];
  // Cycles elapsed since the first detection of the current window.
  assign win_nxt  = win_q + 8'd1;

  // Next-state and statistics logic.
  always_comb begin
    state_d     = state_q;
    hits_d      = hits_q;
    win_d       = win_q;
    det_cnt_d   = det_cnt_q;
    since_d     = since_q;
    last_gap_d  = last_gap_q;
    gap_valid_d = gap_valid_q;
    seen_d      = seen_q;
    burst_d     = 1'b0;
    alarm_d     = alarm_q;

    if (det) begin
      if (det_cnt_q != CNT_MAX) det_cnt_d = det_cnt_q + CNT_W'(1);
      since_d = '0;
      seen_d  = 1'b1;
      // The very first detection only arms the gap measurement.
      if (seen_q) begin
        last_gap_d  = gap_meas;
        gap_valid_d = 1'b1;
      end
    end else if (since_q != GAP_MAX) begin
      since_d = since_q + GAP_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (det) begin
          state_d = TRACK;
          hits_d  = 4'd1;
          win_d   = 8'd0;
        end
      end
      TRACK: begin
        win_d = win_nxt;
        // Completing the burst wins over the window closing on this edge.
        if (det && (hits_q + 4'd1 == BURST_HITS)) begin
          state_d = HOLD;
          hits_d  = hits_q + 4'd1;
          burst_d = 1'b1;
          alarm_d = 1'b1;
        end else if (win_nxt == WIN_LAST) begin
          state_d = IDLE;
          hits_d  = 4'd0;
          win_d   = 8'd0;
        end else if (det) begin
          hits_d = hits_q + 4'd1;
        end
      end
      HOLD: begin
        if (bus.clr_alarm) begin
          alarm_d = 1'b0;
          if (det) begin
            state_d = TRACK;
            hits_d  = 4'd1;
            win_d   = 8'd0;
          end else begin
            state_d = IDLE;
            hits_d  = 4'd0;
            win_d   = 8'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        hits_d  = 4'd0;
        win_d   = 8'd0;
      end
    endcase

    // clr wipes everything and beats clr_alarm.
    if (bus.clr) begin
      state_d     = IDLE;
      hits_d      = 4'd0;
      win_d       = 8'd0;
      det_cnt_d   = '0;
      since_d     = '0;
      last_gap_d  = '0;
      gap_valid_d = 1'b0;
      seen_d      = 1'b0;
      burst_d     = 1'b0;
      alarm_d     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hits_q      <= 4'd0;
      win_q       <= 8'd0;
      det_cnt_q   <= '0;
      since_q     <= '0;
      last_gap_q  <= '0;
      gap_valid_q <= 1'b0;
      seen_q      <= 1'b0;
      burst_q     <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hits_q      <= hits_d;
      win_q       <= win_d;
      det_cnt_q   <= det_cnt_d;
      since_q     <= since_d;
      last_gap_q  <= last_gap_d;
      gap_valid_q <= gap_valid_d;
      seen_q      <= seen_d;
      burst_q     <= burst_d;
      alarm_q     <= alarm_d;
    end
  end

  assign bus.det_cnt   = det_cnt_q;
  assign bus.last_gap  = last_gap_q;
  assign bus.gap_valid = gap_valid_q;
  assign bus.burst     = burst_q;
  assign bus.alarm     = alarm_q;

endmodule

// File: tb/tb_pattern_event_mon.sv
// Self-checking bench for pattern_event_mon: table-driven vectors through an
// expected-value queue plus hand-written multi-cycle sequences.
module tb_pattern_event_mon;

  typedef struct {
    logic        p;
    logic        c;
    logic        ca;
    logic [15:0] det;
    logic [7:0]  gap;
    logic        gv;
    logic        b;
    logic        a;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  pattern_event_mon_if #(.CNT_W(16), .GAP_W(8)) if1 ();
  pattern_event_mon_if #(.CNT_W(4),  .GAP_W(8)) if2 ();

  pattern_event_mon #(.CNT_W(16), .GAP_W(8), .BURST_N(3), .WINDOW(16)) dut (
    .clk(clk), .rst(rst), .bus(if1)
  );

  pattern_event_mon #(.CNT_W(4), .GAP_W(8), .BURST_N(3), .WINDOW(16)) dut2 (
    .clk(clk), .rst(rst), .bus(if2)
  );

  function automatic vec_t mk(input logic p, c, ca, input int det, gap,
                              input logic gv, b, a);
    vec_t v;
    v.p = p; v.c = c; v.ca = ca;
    v.det = 16'(det); v.gap = 8'(gap);
    v.gv = gv; v.b = b; v.a = a;
    return v;
  endfunction

  task automatic step(input logic p, c, ca);
    if1.pattern   = p;
    if1.clr       = c;
    if1.clr_alarm = ca;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, need %0d", nm, act, req);
    end
  endtask

  task automatic check_out(input string nm, input vec_t e);
    n_cmp++;
    if (if1.det_cnt !== e.det || if1.last_gap !== e.gap || if1.gap_valid !== e.gv ||
        if1.burst !== e.b || if1.alarm !== e.a) begin
      n_fail++;
      $display("FAIL %s: got det=%0d gap=%0d gv=%0b burst=%0b alarm=%0b, need det=%0d gap=%0d gv=%0b burst=%0b alarm=%0b",
               nm, if1.det_cnt, if1.last_gap, if1.gap_valid, if1.burst, if1.alarm,
               e.det, e.gap, e.gv, e.b, e.a);
    end
  endtask

  // Push the expectation, apply the stimulus, pop and compare after the edge.
  task automatic step_chk(input string nm, input vec_t e);
    vec_t got;
    exp_q.push_back(e);
    step(e.p, e.c, e.ca);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      got = exp_q.pop_front();
      check_out(nm, got);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, need end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[15];
    logic rb[200];
    logic [1:0] hist;
    int model_cnt;

    if1.pattern = 1'b1; if1.clr = 1'b0; if1.clr_alarm = 1'b0;
    if2.pattern = 1'b1; if2.clr = 1'b0; if2.clr_alarm = 1'b0;

    // Reset with a detection present: it must be discarded.
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    step_chk("reset", mk(1, 0, 0, 0, 0, 0, 0, 0));
    chk_int("reset_state", int'(dut.state_q), 0);
    chk_int("reset_cnt2", int'(if2.det_cnt), 0);
    if2.pattern = 1'b0;
    rst = 1'b0;

    // Detections at 0,5,10 -> burst; HOLD detections; clr_alarm+pattern; clr+pattern.
    tbl[0]  = mk(1, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 2, 5, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 2, 5, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 2, 5, 1, 0, 0);
    tbl[8]  = mk(0, 0, 0, 2, 5, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 2, 5, 1, 0, 0);
    tbl[10] = mk(1, 0, 0, 3, 5, 1, 1, 1);
    tbl[11] = mk(1, 0, 0, 4, 1, 1, 0, 1);
    tbl[12] = mk(1, 0, 1, 5, 1, 1, 0, 0);
    tbl[13] = mk(1, 1, 1, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step_chk($sformatf("tblA[%0d]", i), tbl[i]);
      if (i == 12) begin
        chk_int("ack_track_state", int'(dut.state_q), 1);
        chk_int("ack_track_hits", int'(dut.hits_q), 1);
      end
    end

    // Reset while TRACK is active, with a detection present.
    chk_int("pre_rst_state", int'(dut.state_q), 1);
    rst = 1'b1;
    step_chk("rst_mid_track", mk(1, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    chk_int("rst_state", int'(dut.state_q), 0);
    chk_int("rst_hits", int'(dut.hits_q), 0);
    chk_int("rst_win", int'(dut.win_q), 0);
    chk_int("rst_since", int'(dut.since_q), 0);

    // Detections at 0,8,16: span 16 exceeds the window.
    for (int i = 0; i < 16; i++) step((i % 8) == 0, 1'b0, 1'b0);
    step_chk("span16_det", mk(1, 0, 0, 3, 8, 1, 0, 0));
    chk_int("span16_state", int'(dut.state_q), 1);
    chk_int("span16_hits", int'(dut.hits_q), 1);
    step_chk("span16_after", mk(0, 0, 0, 3, 8, 1, 0, 0));

    // Detections at 0,7,15: span 15 is the boundary and still bursts.
    do_reset();
    for (int i = 0; i < 15; i++) step(i == 0 || i == 7, 1'b0, 1'b0);
    step_chk("span15_burst", mk(1, 0, 0, 3, 8, 1, 1, 1));
    step_chk("span15_pulse_end", mk(0, 0, 0, 3, 8, 1, 0, 1));
    chk_int("hold_state", int'(dut.state_q), 2);
    // clr beats clr_alarm and drops the coincident detection.
    step_chk("clr_over_ack", mk(1, 1, 1, 0, 0, 0, 0, 0));
    chk_int("clr_state", int'(dut.state_q), 0);

    // clr_alarm outside HOLD is ignored; back-to-back detections count separately.
    do_reset();
    step_chk("b2b_0", mk(1, 0, 0, 1, 0, 0, 0, 0));
    step_chk("ack_in_track", mk(0, 0, 1, 1, 0, 0, 0, 0));
    step_chk("b2b_2", mk(1, 0, 0, 2, 2, 1, 0, 0));
    step_chk("b2b_3", mk(1, 0, 0, 3, 1, 1, 1, 1));
    step_chk("alarm_sticky", mk(0, 0, 0, 3, 1, 1, 0, 1));

    // Gap saturation at 300 cycles, then an exact 200-cycle gap.
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 299; i++) step(1'b0, 1'b0, 1'b0);
    step_chk("gap_sat", mk(1, 0, 0, 2, 255, 1, 0, 0));
    for (int i = 0; i < 199; i++) step(1'b0, 1'b0, 1'b0);
    step_chk("gap_200", mk(1, 0, 0, 3, 200, 1, 0, 0));

    // 4-bit counter saturates at 15 over 20 detections.
    do_reset();
    if2.pattern = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (i == 13) chk_int("cnt4_at14", int'(if2.det_cnt), 14);
      if (i == 14) chk_int("cnt4_at15", int'(if2.det_cnt), 15);
    end
    chk_int("cnt4_sat", int'(if2.det_cnt), 15);
    if2.pattern = 1'b0;

    // Random bits through an overlapping "101" detector feeding the monitor.
    do_reset();
    for (int i = 0; i < 200; i++) rb[i] = 1'($urandom_range(0, 1));
    hist = 2'b00;
    for (int i = 0; i < 200; i++) begin
      step(hist == 2'b10 && rb[i], 1'b0, 1'b0);
      hist = {hist[0], rb[i]};
    end
    model_cnt = 0;
    for (int i = 2; i < 200; i++)
      if (rb[i-2] == 1'b1 && rb[i-1] == 1'b0 && rb[i] == 1'b1) model_cnt++;
    chk_int("random_det_cnt", int'(if1.det_cnt), model_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
